// File: rtl/servo_pwm_capture.sv
// Servo PWM receiver: measures the high time of an incoming pulse train and decodes it back
// to the 8-bit command (width = MIN_PULSE_CYC + value*STEP_CYC), flagging bad pulses and loss.
module servo_pwm_capture #(
    parameter int unsigned MIN_PULSE_CYC = 100000,
    parameter int unsigned STEP_CYC      = 392,
    parameter int unsigned TOL_CYC       = 2000,
    parameter int unsigned MAX_HIGH_CYC  = 300000,
    parameter int unsigned TIMEOUT_CYC   = 3000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [7:0]  value,
    output logic        valid,
    output logic        range_err,
    output logic        signal_lost,
    output logic [19:0] width
);

    localparam logic [19:0] MinW     = 20'(MIN_PULSE_CYC);
    localparam logic [19:0] MaxHighW = 20'(MAX_HIGH_CYC);
    localparam logic [19:0] LoBound  =
        20'((MIN_PULSE_CYC > TOL_CYC) ? (MIN_PULSE_CYC - TOL_CYC) : 0);
    localparam logic [19:0] HiBound  = 20'(MIN_PULSE_CYC + 256 * STEP_CYC + TOL_CYC);
    localparam logic [15:0] PrescTop = 16'(STEP_CYC - 1);
    localparam logic [21:0] TimeoutW = 22'(TIMEOUT_CYC);

    typedef enum logic [1:0] {StWaitLow, StWaitRise, StMeasure} state_e;

    state_e      state_q, state_d;
    logic        s1_q, s2_q, s3_q;
    logic [19:0] hcnt_q, hcnt_d;
    logic [15:0] presc_q, presc_d;
    logic [8:0]  quot_q, quot_d;
    logic [8:0]  quot_lat_q, quot_lat_d;
    logic [19:0] width_q, width_d;
    logic        eval_q, eval_d;
    logic        abort_q, abort_d;
    logic [7:0]  value_q, value_d;
    logic        valid_q, valid_d;
    logic        range_err_q, range_err_d;
    logic [21:0] tcnt_q, tcnt_d;
    logic        rise, fall, lost;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;
    assign lost = (tcnt_q >= TimeoutW);

    // Synchronizer resets high so a pin already high at reset never looks like a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWaitLow;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitLow:  if (!s2_q) state_d = StWaitRise;
            StWaitRise: if (rise) state_d = StMeasure;
            StMeasure: begin
                if (fall) begin
                    state_d = StWaitRise;
                end else if (hcnt_q >= MaxHighW) begin
                    state_d = StWaitLow;
                end
            end
            default:    state_d = StWaitLow;
        endcase
    end

    always_comb begin
        hcnt_d      = hcnt_q;
        presc_d     = presc_q;
        quot_d      = quot_q;
        quot_lat_d  = quot_lat_q;
        width_d     = width_q;
        eval_d      = 1'b0;
        abort_d     = 1'b0;
        value_d     = value_q;
        valid_d     = 1'b0;
        range_err_d = 1'b0;
        tcnt_d      = rise ? '0 : ((tcnt_q == '1) ? tcnt_q : tcnt_q + 22'd1);

        unique case (state_q)
            StWaitRise: begin
                if (rise) begin
                    hcnt_d  = 20'd1;
                    presc_d = '0;
                    quot_d  = '0;
                end
            end
            StMeasure: begin
                if (fall) begin
                    width_d    = hcnt_q;
                    quot_lat_d = quot_q;
                    eval_d     = 1'b1;
                end else if (hcnt_q >= MaxHighW) begin
                    width_d = MaxHighW;
                    abort_d = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 20'd1;
                    // quot tracks floor((hcnt - MIN) / STEP) without a divider
                    if (hcnt_q >= MinW) begin
                        if (presc_q == PrescTop) begin
                            presc_d = '0;
                            if (quot_q != '1) quot_d = quot_q + 9'd1;
                        end else begin
                            presc_d = presc_q + 16'd1;
                        end
                    end
                end
            end
            default: ;
        endcase

        // Decode stage runs one cycle after the width is latched.
        if (abort_q) begin
            range_err_d = 1'b1;
        end else if (eval_q) begin
            if (width_q < LoBound || width_q > HiBound) begin
                range_err_d = 1'b1;
            end else if (!lost) begin
                valid_d = 1'b1;
                if (width_q < MinW) begin
                    value_d = '0;
                end else begin
                    value_d = quot_lat_q[8] ? 8'hff : quot_lat_q[7:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q      <= '0;
            presc_q     <= '0;
            quot_q      <= '0;
            quot_lat_q  <= '0;
            width_q     <= '0;
            eval_q      <= 1'b0;
            abort_q     <= 1'b0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            range_err_q <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            presc_q     <= presc_d;
            quot_q      <= quot_d;
            quot_lat_q  <= quot_lat_d;
            width_q     <= width_d;
            eval_q      <= eval_d;
            abort_q     <= abort_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            range_err_q <= range_err_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign value       = value_q;
    assign valid       = valid_q;
    assign range_err   = range_err_q;
    assign width       = width_q;
    assign signal_lost = lost;

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Bench for servo_pwm_capture: table of pulse widths plus hand-written corner sequences,
// with expected strobes queued at stimulus time and checked when the DUT emits them.
module tb_servo_pwm_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in = 1'b0;
    logic [7:0]  value;
    logic        valid;
    logic        range_err;
    logic        signal_lost;
    logic [19:0] width;

    servo_pwm_capture #(
        .MIN_PULSE_CYC(100),
        .STEP_CYC     (4),
        .TOL_CYC      (10),
        .MAX_HIGH_CYC (3000),
        .TIMEOUT_CYC  (2000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .value      (value),
        .valid      (valid),
        .range_err  (range_err),
        .signal_lost(signal_lost),
        .width      (width)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit err;
        int val;
        int wid;
        bit lat;
    } exp_t;

    typedef struct {
        int hi;
        bit err;
        int val;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[8];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   fall_cyc = 0;
    int   rise_cyc = 0;
    bit   post_strobe = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: every valid/range_err strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (post_strobe) begin
            chk("strobe_len", {30'd0, valid, range_err}, 0);
            post_strobe = 0;
        end
        if (valid || range_err) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {30'd0, valid, range_err}, 0);
            end else begin
                e = sb.pop_front();
                chk("kind", {30'd0, valid, range_err}, e.err ? 1 : 2);
                chk("value", int'(value), e.val);
                chk("width", int'(width), e.wid);
                if (e.lat) chk("latency", cyc - fall_cyc, 4);
            end
            post_strobe = 1;
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc != target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        int p;
        @(posedge clk);
        #1;
        pwm_in = 1'b1;
        p = cyc;
        rise_cyc = cyc;
        wait_cyc(p + hi);
        pwm_in = 1'b0;
        fall_cyc = cyc;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    task automatic expect_strobe(input bit err, input int val, input int wid, input bit lat);
        exp_t x;
        x.err = err;
        x.val = val;
        x.wid = wid;
        x.lat = lat;
        sb.push_back(x);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int n;

        vecs[0] = '{100,  1'b0, 0};
        vecs[1] = '{612,  1'b0, 128};
        vecs[2] = '{1120, 1'b0, 255};
        vecs[3] = '{1130, 1'b0, 255};
        vecs[4] = '{95,   1'b0, 0};
        vecs[5] = '{80,   1'b1, 0};
        vecs[6] = '{612,  1'b0, 128};
        vecs[7] = '{1200, 1'b1, 128};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_value", int'(value), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_range_err", int'(range_err), 0);
        chk("rst_width", int'(width), 0);
        chk("rst_signal_lost", int'(signal_lost), 0);

        // Table of in-range, saturating and out-of-range pulses
        for (int i = 0; i < 8; i++) begin
            expect_strobe(vecs[i].err, vecs[i].val, vecs[i].hi, 1'b1);
            pulse(vecs[i].hi, 700);
        end
        chk("table_drained", sb.size(), 0);

        // Stuck-high input: one abort strobe, width saturated, value held
        expect_strobe(1'b1, 128, 3000, 1'b0);
        @(posedge clk);
        #1;
        pwm_in = 1'b1;
        repeat (5000) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        chk("abort_once", sb.size(), 0);

        // Loss of signal after a good pulse
        expect_strobe(1'b0, 75, 400, 1'b1);
        pulse(400, 0);
        n = 0;
        while (!signal_lost && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (signal_lost) chk("lost_delay", cyc - rise_cyc, 2003);
        else chk("lost_timeout", 0, 1);
        chk("lost_value_held", int'(value), 75);
        repeat (497) @(posedge clk);
        @(negedge clk);
        chk("lost_still", int'(signal_lost), 1);

        // Rise clears signal_lost on the next cycle
        expect_strobe(1'b0, 50, 300, 1'b1);
        @(posedge clk);
        #1;
        pwm_in = 1'b1;
        p = cyc;
        repeat (3) @(negedge clk);
        chk("lost_before_rise", int'(signal_lost), 1);
        @(negedge clk);
        chk("lost_cleared", int'(signal_lost), 0);
        wait_cyc(p + 300);
        pwm_in = 1'b0;
        fall_cyc = cyc;
        repeat (700) @(posedge clk);
        #1;
        chk("recover_drained", sb.size(), 0);

        // Reset mid-pulse at hcnt = 400: pulse discarded
        @(posedge clk);
        #1;
        pwm_in = 1'b1;
        p = cyc;
        wait_cyc(p + 402);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_value", int'(value), 0);
        chk("midrst_width", int'(width), 0);
        chk("midrst_flags", {29'd0, valid, range_err, signal_lost}, 0);
        wait_cyc(p + 612);
        pwm_in = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        chk("midrst_no_strobe", sb.size(), 0);
        expect_strobe(1'b0, 128, 612, 1'b1);
        pulse(612, 700);
        chk("midrst_next", sb.size(), 0);

        // Pin high through reset: no valid until a full low-high-low cycle
        pwm_in = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        chk("highrst_value", int'(value), 0);
        expect_strobe(1'b0, 128, 612, 1'b1);
        pulse(612, 700);
        chk("highrst_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
